// File: rtl/counter_uart_reporter.sv
// Snapshots the stopwatch counter, converts it to 4 ASCII decimal digits by repeated subtraction and pushes the frame into the UART TX FIFO.
// Latency: 3..30 conversion cycles, then one byte per cycle; stalls while i_tx_full is high. Optional REPORT_FLAGS_EN appends run/direction flags.
module counter_uart_reporter (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] i_counter,
  input  logic        i_enable,
  input  logic        i_mode,
  input  logic        i_req,
  input  logic        i_tx_full,
  output logic        o_tx_push,
  output logic [7:0]  o_tx_data,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    IDLE,
    CONV_1000,
    CONV_100,
    CONV_10,
    SEND
  } state_t;

`ifdef REPORT_FLAGS_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd5;
`endif

  state_t      state;
  logic [13:0] rem;
  logic [3:0]  d3, d2, d1, d0;
  logic [3:0]  idx;
  logic [7:0]  frame_byte;
  logic [13:0] counter_sat;

`ifdef REPORT_FLAGS_EN
  logic snap_enable;
  logic snap_mode;
`else
  logic unused_flags;
  assign unused_flags = i_enable ^ i_mode;
`endif

  assign counter_sat = (i_counter > 14'd9999) ? 14'd9999 : i_counter;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= 14'd0;
      d3    <= 4'd0;
      d2    <= 4'd0;
      d1    <= 4'd0;
      d0    <= 4'd0;
      idx   <= 4'd0;
`ifdef REPORT_FLAGS_EN
      snap_enable <= 1'b0;
      snap_mode   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            rem   <= counter_sat;
            d3    <= 4'd0;
            d2    <= 4'd0;
            d1    <= 4'd0;
            d0    <= 4'd0;
`ifdef REPORT_FLAGS_EN
            snap_enable <= i_enable;
            snap_mode   <= i_mode;
`endif
            state <= CONV_1000;
          end
        end
        CONV_1000: begin
          if (rem >= 14'd1000) begin
            rem <= rem - 14'd1000;
            d3  <= d3 + 4'd1;
          end else begin
            state <= CONV_100;
          end
        end
        CONV_100: begin
          if (rem >= 14'd100) begin
            rem <= rem - 14'd100;
            d2  <= d2 + 4'd1;
          end else begin
            state <= CONV_10;
          end
        end
        CONV_10: begin
          if (rem >= 14'd10) begin
            rem <= rem - 14'd10;
            d1  <= d1 + 4'd1;
          end else begin
            // remainder is now below 10, so it is the units digit
            d0    <= rem[3:0];
            idx   <= 4'd0;
            state <= SEND;
          end
        end
        SEND: begin
          if (!i_tx_full) begin
            idx <= idx + 4'd1;
            if (idx == LAST_IDX) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      4'd0: frame_byte = {4'h3, d3};
      4'd1: frame_byte = {4'h3, d2};
      4'd2: frame_byte = {4'h3, d1};
      4'd3: frame_byte = {4'h3, d0};
`ifdef REPORT_FLAGS_EN
      4'd4: frame_byte = 8'h20;
      4'd5: frame_byte = snap_enable ? 8'h53 : 8'h52;
      4'd6: frame_byte = snap_mode ? 8'h44 : 8'h55;
      4'd7: frame_byte = 8'h0D;
      4'd8: frame_byte = 8'h0A;
`else
      4'd4: frame_byte = 8'h0D;
      4'd5: frame_byte = 8'h0A;
`endif
      default: frame_byte = 8'h00;
    endcase
  end

  assign o_tx_push = (state == SEND) && !i_tx_full;
  assign o_tx_data = (state == SEND) ? frame_byte : 8'h00;
  assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_counter_uart_reporter.sv
// Directed bench for counter_uart_reporter with an expected-byte scoreboard.
module tb_counter_uart_reporter;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] i_counter;
  logic        i_enable;
  logic        i_mode;
  logic        i_req;
  logic        i_tx_full;
  logic        o_tx_push;
  logic [7:0]  o_tx_data;
  logic        o_busy;

  counter_uart_reporter dut (
    .clk       (clk),
    .rst       (rst),
    .i_counter (i_counter),
    .i_enable  (i_enable),
    .i_mode    (i_mode),
    .i_req     (i_req),
    .i_tx_full (i_tx_full),
    .o_tx_push (o_tx_push),
    .o_tx_data (o_tx_data),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

`ifdef REPORT_FLAGS_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 6;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] expq[$];
  int f_busy, f_first, f_push;
  logic s_busy, s_push;
  logic [7:0] s_data;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample outputs at the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_busy = o_busy;
    s_push = o_tx_push;
    s_data = o_tx_data;
    if (!rst) begin
      if (s_busy) begin
        if (s_push && f_first < 0) f_first = f_busy;
        f_busy++;
      end
      if (s_push) begin
        f_push++;
        check("push_expected", int'(expq.size() > 0), 1);
        if (expq.size() > 0) check("tx_data", int'(s_data), int'(expq.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  task automatic start_req(input int v, input logic en, input logic md);
    int s;
    logic [31:0] vv;
    s  = sat(v);
    vv = v;
    i_counter = vv[13:0];
    i_enable  = en;
    i_mode    = md;
    expq.push_back(8'(8'h30 + s / 1000));
    expq.push_back(8'(8'h30 + (s / 100) % 10));
    expq.push_back(8'(8'h30 + (s / 10) % 10));
    expq.push_back(8'(8'h30 + s % 10));
`ifdef REPORT_FLAGS_EN
    expq.push_back(8'h20);
    expq.push_back(en ? 8'h53 : 8'h52);
    expq.push_back(md ? 8'h44 : 8'h55);
`endif
    expq.push_back(8'h0D);
    expq.push_back(8'h0A);
    f_busy  = 0;
    f_first = -1;
    f_push  = 0;
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (s_busy && n < budget);
    check("frame_timeout", int'(s_busy), 0);
  endtask

  task automatic wait_pushes(input int target);
    int n;
    n = 0;
    while (f_push < target && n < 100) begin
      tick();
      n++;
    end
    check("reach_push_count", f_push, target);
  endtask

  task automatic frame_checks(input string tag, input int v);
    int s, conv;
    s    = sat(v);
    conv = s / 1000 + (s / 100) % 10 + (s / 10) % 10 + 3;
    check({tag, "_conv_cycles"}, f_first, conv);
    check({tag, "_busy_cycles"}, f_busy, conv + FLEN);
    check({tag, "_pushes"}, f_push, FLEN);
    check({tag, "_queue_empty"}, expq.size(), 0);
  endtask

  task automatic frame(input string tag, input int v);
    start_req(v, 1'b0, 1'b0);
    run_idle(200);
    frame_checks(tag, v);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_counter = '0; i_enable = 1'b0; i_mode = 1'b0;
    i_req = 1'b0; i_tx_full = 1'b0;
    f_busy = 0; f_first = -1; f_push = 0;
    tick();
    tick();
    check("reset_busy", int'(o_busy), 0);
    check("reset_push", int'(o_tx_push), 0);
    check("reset_data", int'(o_tx_data), 0);
    rst = 1'b0;
    tick();

    frame("f1234", 1234);
`ifndef REPORT_FLAGS_EN
    check("f1234_busy_literal", f_busy, 15);
`endif
    check("idle_data_zero", int'(o_tx_data), 0);
    frame("f0", 0);
    frame("f9999", 9999);
    frame("f12000", 12000);

    // Back-pressure while the third digit is pending
    start_req(5678, 1'b0, 1'b0);
    wait_pushes(2);
    i_tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_no_push", int'(s_push), 0);
      check("stall_data_hold", int'(s_data), 8'h37);
      check("stall_busy", int'(s_busy), 1);
    end
    i_tx_full = 1'b0;
    run_idle(100);
    check("stall_pushes", f_push, FLEN);
    check("stall_queue_empty", expq.size(), 0);

    // Requests while busy, including on the final push, are dropped
    start_req(305, 1'b0, 1'b0);
    tick();
    tick();
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    wait_pushes(FLEN - 1);
    i_req = 1'b1;
    tick();
    i_req = 1'b0;
    run_idle(100);
    check("drop_pushes", f_push, FLEN);
    f_busy = 0;
    repeat (40) tick();
    check("drop_no_busy", f_busy, 0);
    check("drop_no_extra_push", f_push, FLEN);
    check("drop_queue_empty", expq.size(), 0);

    // Reset in the middle of SEND abandons the frame
    start_req(1234, 1'b0, 1'b0);
    wait_pushes(2);
    rst = 1'b1;
    expq.delete();
    tick();
    rst = 1'b0;
    check("rst_mid_busy", int'(o_busy), 0);
    check("rst_mid_push", int'(o_tx_push), 0);
    f_busy = 0;
    f_push = 0;
    repeat (20) tick();
    check("rst_mid_no_push", f_push, 0);
    check("rst_mid_no_busy", f_busy, 0);
    frame("after_rst", 4321);

    // Inputs changed after the snapshot must not affect the frame
    start_req(42, 1'b0, 1'b1);
    tick();
    i_counter = 14'd9000;
    i_enable  = 1'b1;
    i_mode    = 1'b0;
    run_idle(200);
    frame_checks("snap42", 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
